// File: rtl/lcd_timing_pattern_gen.sv
// lcd_timing_pattern_gen: parallel-RGB TFT timing generator with built-in test patterns.
// Ports: iCLK pixel clock, iRST async active-high reset, iMODE pattern select (frame-synchronous),
// iSOLID_RGB solid colour, iEXT_RGB external pixel; oREQ/oX/oY unregistered next-pixel request,
// oHD/oVD/oDEN/oLCD_* registered panel outputs, oFRAME_START/oFRAME_CNT frame marker and count.
module lcd_timing_pattern_gen #(
  parameter int H_ACTIVE = 480,
  parameter int H_FRONT  = 2,
  parameter int H_SYNC   = 41,
  parameter int H_BACK   = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FRONT  = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BACK   = 2,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int DW       = 8
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [2:0]      iMODE,
  input  logic [3*DW-1:0] iSOLID_RGB,
  input  logic [3*DW-1:0] iEXT_RGB,
  output logic            oREQ,
  output logic [10:0]     oX,
  output logic [9:0]      oY,
  output logic            oHD,
  output logic            oVD,
  output logic            oDEN,
  output logic [DW-1:0]   oLCD_R,
  output logic [DW-1:0]   oLCD_G,
  output logic [DW-1:0]   oLCD_B,
  output logic            oFRAME_START,
  output logic [15:0]     oFRAME_CNT
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam logic [10:0] HS  = 11'(H_SYNC);
  localparam logic [10:0] HSB = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] HAE = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [10:0] HL  = 11'(H_TOTAL - 1);
  localparam logic [9:0]  VS  = 10'(V_SYNC);
  localparam logic [9:0]  VSB = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  VAE = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [9:0]  VL  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V1  = 10'(V_ACTIVE / 3);
  localparam logic [9:0]  V2  = 10'(2 * V_ACTIVE / 3);

  logic [10:0]     r_h;
  logic [9:0]      r_v;
  logic [2:0]      r_mode;
  logic            w_h_last, w_v_last, w_first;
  logic [2:0]      w_bar;
  logic [DW-1:0]   w_g;
  logic [3*DW-1:0] w_rgb;

  assign w_h_last = r_h == HL;
  assign w_v_last = r_v == VL;
  assign w_first  = r_h == 11'd0 && r_v == 10'd0;
  assign oREQ     = r_h >= HSB && r_h < HAE && r_v >= VSB && r_v < VAE;
  assign oX       = oREQ ? r_h - HSB : '0;
  assign oY       = oREQ ? r_v - VSB : '0;
  assign w_g      = DW'(oX);

  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      r_h    <= '0;
      r_v    <= '0;
      r_mode <= '0;
    end else begin
      r_h <= w_h_last ? '0 : r_h + 11'd1;
      if (w_h_last) r_v <= w_v_last ? '0 : r_v + 10'd1;
      if (w_h_last && w_v_last) r_mode <= iMODE;
    end

  // Bar index is the last threshold k*H_ACTIVE/8 that oX has reached; colour bits then fall
  // straight out of the index: R=~k[1], G=~k[2], B=~k[0] gives white..black in bar order.
  always_comb begin
    w_bar = '0;
    for (int k = 1; k < 8; k++)
      if (oX >= 11'(k * H_ACTIVE / 8)) w_bar = 3'(k);
    w_rgb = !oREQ           ? '0 :
            r_mode == 3'd0  ? {3{w_g}} :
            r_mode == 3'd1  ? (oY < V1 ? {w_g, {2*DW{1'b0}}} :
                               oY < V2 ? {{DW{1'b0}}, w_g, {DW{1'b0}}} : {{2*DW{1'b0}}, w_g}) :
            r_mode == 3'd2  ? {{DW{~w_bar[1]}}, {DW{~w_bar[2]}}, {DW{~w_bar[0]}}} :
            r_mode == 3'd3  ? {3*DW{oX[4] ^ oY[4]}} :
            r_mode == 3'd4  ? iSOLID_RGB :
            r_mode == 3'd5  ? iEXT_RGB : '0;
  end

  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      oHD                      <= ~HS_POL;
      oVD                      <= ~VS_POL;
      oDEN                     <= 1'b0;
      {oLCD_R, oLCD_G, oLCD_B} <= '0;
      oFRAME_START             <= 1'b0;
      oFRAME_CNT               <= '0;
    end else begin
      oHD                      <= r_h < HS ? HS_POL : ~HS_POL;
      oVD                      <= r_v < VS ? VS_POL : ~VS_POL;
      oDEN                     <= oREQ;
      {oLCD_R, oLCD_G, oLCD_B} <= w_rgb;
      oFRAME_START             <= w_first;
      if (w_first) oFRAME_CNT <= oFRAME_CNT + 16'd1;
    end
endmodule

// File: tb/tb_lcd_timing_pattern_gen.sv
// tb_lcd_timing_pattern_gen: randomized scoreboard bench for lcd_timing_pattern_gen.
module tb_lcd_timing_pattern_gen;
  localparam int HA = 264, HF = 2, HSY = 4, HB = 3;
  localparam int VA = 24, VF = 2, VSY = 3, VB = 2;
  localparam int HT = HA + HF + HSY + HB, VT = VA + VF + VSY + VB, FL = HT * VT;
  localparam int HSB = HSY + HB, VSB = VSY + VB;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  mode = '0;
  logic [23:0] solid = '0, ext = '0;
  logic        oREQ, oHD, oVD, oDEN, oFS;
  logic [10:0] oX;
  logic [9:0]  oY;
  logic [7:0]  oR, oG, oB;
  logic [15:0] oCNT;

  lcd_timing_pattern_gen #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB), .HS_POL(1'b0), .VS_POL(1'b0), .DW(8))
  dut (.iCLK(clk), .iRST(rst), .iMODE(mode), .iSOLID_RGB(solid), .iEXT_RGB(ext),
    .oREQ(oREQ), .oX(oX), .oY(oY), .oHD(oHD), .oVD(oVD), .oDEN(oDEN),
    .oLCD_R(oR), .oLCD_G(oG), .oLCD_B(oB), .oFRAME_START(oFS), .oFRAME_CNT(oCNT));

  logic        s_req, s_hd, s_vd, s_den, s_fs;
  logic [10:0] s_x;
  logic [9:0]  s_y;
  logic [7:0]  s_r, s_g, s_b;
  logic [15:0] s_cnt;

  lcd_timing_pattern_gen #(.H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .HS_POL(1'b1), .VS_POL(1'b1), .DW(8))
  dut_small (.iCLK(clk), .iRST(rst), .iMODE(3'd0), .iSOLID_RGB(24'd0), .iEXT_RGB(24'd0),
    .oREQ(s_req), .oX(s_x), .oY(s_y), .oHD(s_hd), .oVD(s_vd), .oDEN(s_den),
    .oLCD_R(s_r), .oLCD_G(s_g), .oLCD_B(s_b), .oFRAME_START(s_fs), .oFRAME_CNT(s_cnt));

  typedef struct packed {
    logic        req;
    logic [10:0] x;
    logic [9:0]  y;
    logic        hd, vd, den;
    logic [23:0] rgb;
    logic        fs;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   vectors = 0, fails = 0;
  int   n = 0, cur_mode = 0, next_mode = 0;
  int   sched [5] = '{3, 2, 5, 1, 4};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_rgb(int m, int ax, int ay, bit act, logic [23:0] sol, logic [23:0] ex);
    logic [7:0] g;
    g = 8'(ax % 256);
    if (!act) return 24'h0;
    case (m)
      0: return {g, g, g};
      1: return ay < VA / 3 ? {g, 16'h0} : ay < 2 * VA / 3 ? {8'h0, g, 8'h0} : {16'h0, g};
      2: begin
        for (int k = 0; k < 8; k++)
          if (ax >= k * HA / 8 && ax < (k + 1) * HA / 8) return BARS[k];
        return 24'h0;
      end
      3: return ((ax / 16 + ay / 16) % 2) == 1 ? 24'hFFFFFF : 24'h0;
      4: return sol;
      5: return ex;
      default: return 24'h0;
    endcase
  endfunction

  // Drive one counter position's inputs and queue what the DUT must show for it.
  task automatic step();
    int pos, h, v, ax, ay;
    bit act;
    logic [7:0] r8;
    exp_t e;
    pos = n % FL;
    h = pos % HT;
    v = pos / HT;
    ax = h - HSB;
    ay = v - VSB;
    act = h >= HSB && h < HSB + HA && v >= VSB && v < VSB + VA;
    if (pos == 0 && n != 0) cur_mode = next_mode;
    if (pos == FL - 1) begin
      next_mode = (n / FL < 5) ? sched[n / FL] : int'($urandom_range(0, 7));
      mode = 3'(next_mode);
    end else mode = 3'($urandom_range(0, 7));
    solid = 24'($urandom);
    r8 = 8'($urandom);
    ext = {oX[7:0], oY[7:0], r8};
    e.req = act;
    e.x   = act ? 11'(ax) : 11'd0;
    e.y   = act ? 10'(ay) : 10'd0;
    e.hd  = !(h < HSY);
    e.vd  = !(v < VSY);
    e.den = act;
    e.rgb = model_rgb(cur_mode, ax, ay, act, solid, {8'(ax), 8'(ay), r8});
    e.fs  = pos == 0;
    e.cnt = 16'(n / FL + 1);
    q.push_back(e);
    n++;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_req"}, oREQ, 0);
    check({tag, "_x"}, oX, 0);
    check({tag, "_y"}, oY, 0);
    check({tag, "_hd"}, oHD, 1);
    check({tag, "_vd"}, oVD, 1);
    check({tag, "_den"}, oDEN, 0);
    check({tag, "_rgb"}, {oR, oG, oB}, 0);
    check({tag, "_fs"}, oFS, 0);
    check({tag, "_cnt"}, oCNT, 0);
    check({tag, "_small_hd"}, s_hd, 0);
    check({tag, "_small_vd"}, s_vd, 0);
  endtask

  initial begin : monitor
    exp_t e;
    logic mreq;
    logic [10:0] mx;
    logic [9:0] my;
    forever begin
      @(negedge clk);
      #2;
      mreq = oREQ;
      mx = oX;
      my = oY;
      @(posedge clk);
      #1;
      if (!rst) begin
        if (q.size() == 0) begin
          vectors++;
          fails++;
          $display("FAIL sb_underflow: got empty queue expected an entry at %0t", $time);
        end else begin
          e = q.pop_front();
          check("req", mreq, e.req);
          check("x", mx, e.x);
          check("y", my, e.y);
          check("hd", oHD, e.hd);
          check("vd", oVD, e.vd);
          check("den", oDEN, e.den);
          check("rgb", {oR, oG, oB}, e.rgb);
          check("fs", oFS, e.fs);
          check("cnt", oCNT, e.cnt);
        end
      end
    end
  end

  initial begin : small_timing
    int h, v;
    @(negedge rst);
    for (int c = 0; c < 3 * 84; c++) begin
      @(posedge clk);
      #1;
      h = c % 12;
      v = (c % 84) / 12;
      check("small_hd", s_hd, h < 2 ? 1 : 0);
      check("small_vd", s_vd, v < 1 ? 1 : 0);
      check("small_den", s_den, (h >= 3 && h < 11 && v >= 2 && v < 6) ? 1 : 0);
      check("small_fs", s_fs, (c % 84 == 0) ? 1 : 0);
      check("small_cnt", s_cnt, c / 84 + 1);
    end
  end

  initial begin : stimulus
    int x_pos;
    x_pos = (VSB + 5) * HT + HSB + 100;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    @(negedge clk);
    rst = 1'b0;
    step();
    repeat (6 * FL + x_pos - 1) begin
      @(negedge clk);
      step();
    end
    @(negedge clk);
    check("pre_reset_den", oDEN, 1);
    #5 rst = 1'b1;
    #1 reset_checks("async_rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n = 0;
    cur_mode = 0;
    next_mode = 0;
    step();
    repeat (2 * HT) begin
      @(negedge clk);
      step();
    end
    @(posedge clk);
    #3;
    check("sb_drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/lcd_timing_pattern_gen.md
# lcd_timing_pattern_gen

Parametrised LCD timing generator with a built-in test-pattern engine. It produces HD/VD/DEN and RGB for a parallel-RGB TFT panel. Horizontal and vertical timing, sync polarity and colour depth are set by parameters. Eight runtime-selectable modes cover gray ramp, RGB bands, colour bars, checkerboard, solid colour, external-pixel passthrough and black. Mode switching is frame-synchronous. The block sits between the pixel-clock PLL and the panel pins, and also serves as the timing master for a frame-buffer reader through oREQ/oX/oY.

## Interface
- H_ACTIVE, 480, visible pixels per line
- H_FRONT, 2, front porch clocks
- H_SYNC, 41, HD pulse width in clocks
- H_BACK, 2, back porch clocks
- V_ACTIVE, 272, visible lines
- V_FRONT, 2, front porch lines
- V_SYNC, 10, VD pulse width in lines
- V_BACK, 2, back porch lines
- HS_POL, 0, active level of oHD
- VS_POL, 0, active level of oVD
- DW, 8, bits per colour channel
- iCLK  in  1  pixel clock; all logic on rising edge
- iRST  in  1  asynchronous, active-high reset
- iMODE  in  3  pattern select; sampled once per frame
- iSOLID_RGB  in  3*DW  solid colour {R,G,B} for mode 4
- iEXT_RGB  in  3*DW  external pixel {R,G,B} for mode 5; sampled when oREQ=1
- oREQ  out  1  next-pixel request: current counter position is active
- oX  out  11  active column of requested pixel; 0 when oREQ=0
- oY  out  10  active row of requested pixel; 0 when oREQ=0
- oHD, oVD  out  1 each  registered syncs
- oDEN  out  1  registered data enable
- oLCD_R, oLCD_G, oLCD_B  out  DW each  registered colour
- oFRAME_START  out  1  one-cycle pulse aligned with the first output cycle of a frame
- oFRAME_CNT  out  16  frames started since reset, wrapping

## Operation
- Line and frame totals: H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT; V_TOTAL likewise.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt advances when h_cnt wraps and itself wraps after V_TOTAL-1.
- Region order in each dimension: sync, back porch, active, front porch.
- Active test: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE), with the same rule applied to v_cnt.
- Active coordinates: ax = h_cnt-(H_SYNC+H_BACK); ay likewise.
- oREQ, oX and oY are decoded from the counter registers with no extra register stage.
- HD is active when h_cnt<H_SYNC. VD is active when v_cnt<V_SYNC, for whole lines.
- mode_q loads iMODE on the cycle h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1. A change mid-frame therefore takes effect on the next frame.
- Pattern modes (mode_q):
  - 0: all channels = ax[DW-1:0].
  - 1: ay<V_ACTIVE/3 gives R=ax[DW-1:0]; ay<2*V_ACTIVE/3 gives G; otherwise B. Unselected channels are 0. Integer division.
  - 2: eight vertical bars, bar k for ax in [k*H_ACTIVE/8, (k+1)*H_ACTIVE/8). Colours in order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is either all-ones or 0.
  - 3: checkerboard; white when ax[4]^ay[4]=1, else black.
  - 4: iSOLID_RGB.
  - 5: iEXT_RGB.
  - 6, 7: black.
- Outside the active area all colour outputs are 0 in every mode.
- oFRAME_CNT increments by 1 in the same cycle that oFRAME_START is high, wrapping from 0xFFFF to 0.

## Timing
- Output stage: a one-register pipeline. Outputs after edge n reflect the counter state before edge n.
- oHD/oVD/oDEN/oLCD_* lag oREQ/oX/oY by exactly 1 cycle.
- iEXT_RGB sampled on a cycle where oREQ=1 appears on oLCD_* on the next cycle, with oDEN=1.
- oFRAME_START is high for 1 cycle: the output cycle of h_cnt=0, v_cnt=0.
- Reset values while iRST=1:
  - h_cnt, v_cnt, mode_q, oFRAME_CNT = 0.
  - oHD=~HS_POL, oVD=~VS_POL.
  - oDEN=0, oLCD_*=0, oFRAME_START=0.
  - oREQ=0, oX=0, oY=0.
- Reset asserted mid-frame clears all state immediately, with no completion of the line.
- After release, the first rising edge produces oFRAME_START=1 and oFRAME_CNT=1, and mode_q=0 is used for that frame.
- With the defaults, H_TOTAL=525 and V_TOTAL=286.
- With the defaults, oDEN is high for 480 consecutive cycles per line on 272 lines. The first DEN cycle of a line is at h_cnt=43, shown on the output one cycle later.
- Widths: oX, oY and the counters must not overflow. H_TOTAL≤2048 and V_TOTAL≤1024 are required parameter constraints.

## Test plan
- Defaults, mode 0, after reset:
  - per frame, oHD low for 41 cycles of every 525 and oVD low for 10×525 cycles of every 286×525;
  - oDEN high 480×272 cycles;
  - first active pixel RGB=0x00, 256th=0xFF, 257th=0x00.
- Mode 2, defaults: on line ay=0 (active row 0), pixels ax=0..59 are FF/FF/FF, ax=60..119 are FF/FF/00, and ax=420..479 are 00/00/00.
- iMODE changed 0→3 at mid-frame: the rest of that frame is still the gray ramp. The next frame's pixel (ax=16, ay=0) is white and (16,16) is black.
- Mode 5: iEXT_RGB driven as {oX[7:0], oY[7:0], 8'hA5} each oREQ cycle. The output at (ax=10, ay=3) is 0A/03/A5, one cycle after oREQ.
- HS_POL=1, VS_POL=1, small timing (H_ACTIVE=8, porches 1, H_SYNC=2, V 4/1/1/1):
  - oHD high 2 of 12 cycles;
  - oFRAME_START period = 84 cycles;
  - oFRAME_CNT increments per pulse.
- iRST pulsed mid-active-line: outputs go to reset values asynchronously. After release, oFRAME_START is high on the first edge, and the frame count restarts at 1.
